axi_elastic_buffer: RTL and testbench
=====================================

Name: axi_elastic_buffer

Overview:
- Parametrised elastic buffer for valid/ready streams. Next generation of the single-stage register slice.
- Adds configurable depth, a TLAST sideband, an optional packet-store-and-forward mode, a fill-level output and a synchronous flush.
- Sits between stream producers and consumers wherever timing isolation and rate decoupling are both needed.
- Sustains full throughput (one transfer per cycle on each side).

Parameters:
- DATA_WIDTH, 32, payload width in bits.
- DEPTH, 4, storage entries; power of two, 2..256.
- PACKET_MODE, 0, 0 = cut-through; 1 = m_axi_valid withheld until a complete packet (last seen) is stored or the buffer is full.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- resetn  in  1  synchronous, active-low reset.
- flush  in  1  synchronous clear of all stored entries.
- s_axi_valid  in  1  upstream valid.
- s_axi_ready  out  1  upstream ready.
- s_axi_data  in  DATA_WIDTH  upstream payload.
- s_axi_last  in  1  upstream end-of-packet.
- m_axi_valid  out  1  downstream valid.
- m_axi_ready  in  1  downstream ready.
- m_axi_data  out  DATA_WIDTH  downstream payload.
- m_axi_last  out  1  downstream end-of-packet.
- level  out  clog2(DEPTH)+1  number of stored entries.

Behaviour:
- Reset is resetn, synchronous, active-low, on clock clk. While resetn=0 at an edge:
  - read pointer, write pointer, level and pkt_cnt cleared to 0;
  - full register cleared to 0, so s_axi_ready=1 after reset;
  - m_axi_valid=0 after reset;
  - storage contents undefined, not reset; m_axi_data/m_axi_last are don't-care while m_axi_valid=0.
- Storage:
  - register array of DEPTH entries, each {last, data};
  - write pointer and read pointer wrap modulo DEPTH;
  - level tracked in a counter register.
- Write: on an edge with s_axi_valid & s_axi_ready & ~flush, store {s_axi_last, s_axi_data} at the write pointer and increment it.
- Read: on an edge with m_axi_valid & m_axi_ready & ~flush, increment the read pointer.
- m_axi_data and m_axi_last are driven from the entry at the read pointer.
- No combinational path from any s_* input to any m_* output, nor from m_axi_ready to s_axi_ready.
- s_axi_ready = ~full, where full is a register:
  - full is set when level reaches DEPTH;
  - full is cleared on the same edge that pops an entry.
- Latency:
  - an entry written into an empty buffer at edge k gives m_axi_valid=1 in the cycle after edge k (1-cycle latency);
  - in PACKET_MODE=1 this holds only if that entry qualifies (see packet mode).
- Level update:
  - simultaneous push and pop: level unchanged; full and empty state preserved;
  - at full, a pop and a push cannot occur on the same edge, since s_axi_ready=0 for that cycle; s_axi_ready rises the cycle after the pop.
- Empty: m_axi_valid=0. Full: level=DEPTH.
- PACKET_MODE=0: m_axi_valid = (level != 0) & ~flush.
- PACKET_MODE=1:
  - pkt_cnt counts stored entries with last=1: incremented on a push of last, decremented on a pop of last, unchanged if both occur on one edge;
  - m_axi_valid = (level != 0) & (pkt_cnt != 0 | full) & ~flush;
  - the full override prevents deadlock on packets longer than DEPTH.
- Valid stability: once m_axi_valid=1, data/last remain stable and valid stays high until the handshake. Flush and reset are the only exceptions.
- Flush:
  - flush=1 forces s_axi_ready=0 and m_axi_valid=0 combinationally;
  - no transfer occurs during a flush cycle;
  - at the edge, pointers, level, pkt_cnt and full are cleared;
  - s_axi_ready=1 in the following cycle.
- Reset mid-operation: all stored data is discarded, identically to flush.
- level is registered and reflects state after the last edge.

Test Plan:
- Reset, then push 0xA0..0xA3 with m_axi_ready=0:
  - level 1,2,3,4;
  - s_axi_ready=0 after the 4th push;
  - the 5th word 0xA4 is held by upstream and not accepted.
- From full, m_axi_ready=1 with s_axi_valid=1 continuous:
  - outputs 0xA0,0xA1,… in order;
  - s_axi_ready returns the cycle after the first pop;
  - no loss or duplication over 100 random-stall words (scoreboard).
- Streaming at level 2 with both sides active every cycle: level stays 2; 1 word per cycle throughput; wrap-around across 3×DEPTH words preserves order.
- PACKET_MODE=1, DEPTH=4:
  - push 0x10,0x11 (last=0): m_axi_valid stays 0;
  - push 0x12 last=1: m_axi_valid=1 the next cycle and 3 words drain with m_axi_last on 0x12;
  - then push a 6-word packet: valid asserts when level=4 (full override).
- Flush with level=3:
  - ready and valid are 0 in the flush cycle;
  - next cycle level=0, m_axi_valid=0, s_axi_ready=1;
  - a new word 0x55 then emerges first.
- Assert resetn=0 mid-packet in PACKET_MODE=1: level=0, pkt_cnt=0, m_axi_valid=0 after the edge; the next packet forwards correctly.

Source files
------------

// File: rtl/axi_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : axi_elastic_buffer
//  Purpose  : Parametrised elastic buffer for valid/ready streams with a TLAST
//             sideband, optional packet store-and-forward, a fill-level output
//             and a synchronous flush. Sustains one transfer per cycle on
//             each side and registers all cross-side paths.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk          in   clock, all state updates on the rising edge
//    resetn       in   synchronous active-low reset
//    flush        in   synchronous clear of all stored entries
//    s_axi_valid  in   upstream valid
//    s_axi_ready  out  upstream ready
//    s_axi_data   in   upstream payload   [DATA_WIDTH-1:0]
//    s_axi_last   in   upstream end-of-packet
//    m_axi_valid  out  downstream valid
//    m_axi_ready  in   downstream ready
//    m_axi_data   out  downstream payload [DATA_WIDTH-1:0]
//    m_axi_last   out  downstream end-of-packet
//    level        out  number of stored entries [clog2(DEPTH):0]
// ============================================================================
module axi_elastic_buffer #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH       = 4,
    parameter int PACKET_MODE = 0
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     s_axi_valid,
    output logic                     s_axi_ready,
    input  logic [DATA_WIDTH-1:0]    s_axi_data,
    input  logic                     s_axi_last,
    output logic                     m_axi_valid,
    input  logic                     m_axi_ready,
    output logic [DATA_WIDTH-1:0]    m_axi_data,
    output logic                     m_axi_last,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_LVL_W = c_PTR_W + 1;

    // Each entry holds {last, data}; storage is deliberately not reset.
    logic [DATA_WIDTH:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wptr;
    logic [c_PTR_W-1:0]   r_rptr;
    logic [c_LVL_W-1:0]   r_level;
    logic                 r_full;

    logic                 w_push;
    logic                 w_pop;
    logic                 w_pkt_ok;
    logic [c_LVL_W-1:0]   w_level_nxt;

    // Ready depends only on the full register and flush, never on m_axi_ready.
    assign s_axi_ready = ~r_full & ~flush;
    assign w_push      = s_axi_valid & s_axi_ready;
    assign w_pop       = m_axi_valid & m_axi_ready;

    assign m_axi_valid = (r_level != '0) & w_pkt_ok & ~flush;
    assign {m_axi_last, m_axi_data} = r_mem[r_rptr];
    assign level       = r_level;

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop) begin
            w_level_nxt = r_level + c_LVL_W'(1);
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - c_LVL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {s_axi_last, s_axi_data};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_level <= '0;
            r_full  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_PTR_W'(1);
            end
            r_level <= w_level_nxt;
            // A pop at full always lowers the level, so this also clears full
            // on the popping edge.
            r_full  <= (w_level_nxt == c_LVL_W'(DEPTH));
        end
    end

    generate
        if (PACKET_MODE != 0) begin : g_packet
            logic [c_LVL_W-1:0] r_pkt_cnt;
            logic               w_push_last;
            logic               w_pop_last;

            assign w_push_last = w_push & s_axi_last;
            assign w_pop_last  = w_pop & m_axi_last;

            always_ff @(posedge clk) begin
                if (!resetn || flush) begin
                    r_pkt_cnt <= '0;
                end else if (w_push_last && !w_pop_last) begin
                    r_pkt_cnt <= r_pkt_cnt + c_LVL_W'(1);
                end else if (w_pop_last && !w_push_last) begin
                    r_pkt_cnt <= r_pkt_cnt - c_LVL_W'(1);
                end
            end

            // Releasing at full lets packets longer than DEPTH drain instead
            // of deadlocking.
            assign w_pkt_ok = (r_pkt_cnt != '0) | r_full;
        end else begin : g_cut_through
            assign w_pkt_ok = 1'b1;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_axi_elastic_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_axi_elastic_buffer
//  Purpose  : Self-checking bench for axi_elastic_buffer. Two instances run
//             side by side: index 0 in cut-through mode, index 1 in packet
//             mode. A queue per instance models the stored contents; the
//             expected valid/ready/level/data are derived from that queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_axi_elastic_buffer;

    localparam int DW    = 8;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    logic [1:0]    flush   = '0;
    logic [1:0]    s_valid = '0;
    logic [1:0]    s_last  = '0;
    logic [1:0]    m_ready = '0;
    logic [1:0]    s_ready;
    logic [1:0]    m_valid;
    logic [1:0]    m_last;
    logic [DW-1:0] s_data [2];
    logic [DW-1:0] m_data [2];
    logic [LW-1:0] level  [2];

    int checks   = 0;
    int errors   = 0;
    int tmo_cnt  = 0;
    int tmo_seen = 0;
    bit armed    = 0;

    logic [DW:0] sb [2][$];

    always #5 clk = ~clk;

    axi_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(0)) u_dut0 (
        .clk(clk), .resetn(resetn), .flush(flush[0]),
        .s_axi_valid(s_valid[0]), .s_axi_ready(s_ready[0]),
        .s_axi_data(s_data[0]), .s_axi_last(s_last[0]),
        .m_axi_valid(m_valid[0]), .m_axi_ready(m_ready[0]),
        .m_axi_data(m_data[0]), .m_axi_last(m_last[0]),
        .level(level[0])
    );

    axi_elastic_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PACKET_MODE(1)) u_dut1 (
        .clk(clk), .resetn(resetn), .flush(flush[1]),
        .s_axi_valid(s_valid[1]), .s_axi_ready(s_ready[1]),
        .s_axi_data(s_data[1]), .s_axi_last(s_last[1]),
        .m_axi_valid(m_valid[1]), .m_axi_ready(m_ready[1]),
        .m_axi_data(m_data[1]), .m_axi_last(m_last[1]),
        .level(level[1])
    );

    task automatic chk(input string nm, input int i, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d] got %0h expected %0h at %0t", nm, i, act, exp, $time);
        end
    endtask

    // Monitor: compares DUT outputs with the queue model between edges, then
    // advances the model by the handshakes that will occur at the next edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int          n;
            bit          has_last;
            bit          ev;
            bit          er;
            logic [DW:0] head;
            if (armed) begin
                n = sb[i].size();
                has_last = 1'b0;
                for (int k = 0; k < n; k++) begin
                    if (sb[i][k][DW]) has_last = 1'b1;
                end
                ev = (n != 0) && !flush[i] && (i == 0 || has_last || n == DEPTH);
                er = (n != DEPTH) && !flush[i];
                chk("m_valid", i, int'(m_valid[i]), int'(ev));
                chk("s_ready", i, int'(s_ready[i]), int'(er));
                chk("level", i, int'(level[i]), n);
                if (ev && m_valid[i]) begin
                    head = sb[i][0];
                    chk("m_data", i, int'(m_data[i]), int'(head[DW-1:0]));
                    chk("m_last", i, int'(m_last[i]), int'(head[DW]));
                end
                if (!resetn || flush[i]) begin
                    sb[i].delete();
                end else begin
                    if (ev && m_ready[i]) void'(sb[i].pop_front());
                    if (er && s_valid[i]) sb[i].push_back({s_last[i], s_data[i]});
                end
            end
        end
        if (tmo_cnt != tmo_seen) begin
            chk("handshake_timeout", 0, tmo_cnt - tmo_seen, 0);
            tmo_seen = tmo_cnt;
        end
        if (!resetn) armed = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int t = 0; t < n; t++) step();
    endtask

    task automatic push(input int i, input logic [DW-1:0] d, input logic l);
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        s_last[i]  = l;
        for (int t = 0; t < 64; t++) begin
            @(negedge clk);
            #1;
            if (s_ready[i]) begin
                step();
                s_valid[i] = 1'b0;
                return;
            end
            step();
        end
        s_valid[i] = 1'b0;
        tmo_cnt++;
    endtask

    // Random-stall streaming; a presented word stays stable until accepted.
    task automatic stream(input int i, input int nwords, input logic [DW-1:0] d0,
                          input int pv, input int pr, input bit rlast);
        int          sent;
        int          budget;
        bit          acc;
        logic [DW-1:0] d;
        sent   = 0;
        budget = nwords * 40;
        d      = d0;
        while (sent < nwords && budget > 0) begin
            if (!s_valid[i]) begin
                s_valid[i] = ($urandom_range(99) < pv);
                s_data[i]  = d;
                s_last[i]  = rlast ? ($urandom_range(3) == 0) : 1'b0;
            end
            m_ready[i] = ($urandom_range(99) < pr);
            @(negedge clk);
            #1;
            acc = s_valid[i] && s_ready[i];
            step();
            if (acc) begin
                sent++;
                d++;
                s_valid[i] = 1'b0;
            end
            budget--;
        end
        s_valid[i] = 1'b0;
        if (sent < nwords) tmo_cnt++;
    endtask

    initial begin
        s_data[0] = '0;
        s_data[1] = '0;
        steps(2);
        resetn = 1'b1;
        step();

        // Fill cut-through instance to full, then hold a fifth word.
        m_ready[0] = 1'b0;
        for (int k = 0; k < 4; k++) push(0, 8'hA0 + 8'(k), 1'b0);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'hA4;
        steps(3);
        // Release downstream; A4 is accepted the cycle after the first pop.
        m_ready[0] = 1'b1;
        push(0, 8'hA4, 1'b0);
        stream(0, 100, 8'hA5, 70, 60, 1'b0);
        m_ready[0] = 1'b1;
        steps(8);

        // Streaming at level 2 with both sides active every cycle.
        m_ready[0] = 1'b0;
        push(0, 8'h01, 1'b0);
        push(0, 8'h02, 1'b0);
        m_ready[0] = 1'b1;
        stream(0, 3 * DEPTH, 8'h03, 100, 100, 1'b0);
        steps(6);

        // Flush at level 3, then a fresh word must come out first.
        m_ready[0] = 1'b0;
        for (int k = 0; k < 3; k++) push(0, 8'hC0 + 8'(k), 1'b0);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h77;
        flush[0]   = 1'b1;
        step();
        flush[0]   = 1'b0;
        s_valid[0] = 1'b0;
        step();
        push(0, 8'h55, 1'b0);
        m_ready[0] = 1'b1;
        steps(4);

        // Packet mode: partial packet withheld, released on last.
        m_ready[1] = 1'b1;
        push(1, 8'h10, 1'b0);
        push(1, 8'h11, 1'b0);
        steps(3);
        push(1, 8'h12, 1'b1);
        steps(5);
        // Six-word packet: released by the full override.
        for (int k = 0; k < 6; k++) push(1, 8'h20 + 8'(k), (k == 5));
        steps(8);

        // Reset mid-packet, then a clean packet.
        push(1, 8'h30, 1'b0);
        push(1, 8'h31, 1'b0);
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        push(1, 8'h40, 1'b0);
        push(1, 8'h41, 1'b0);
        push(1, 8'h42, 1'b1);
        steps(6);

        // Randomised packet traffic.
        stream(1, 80, 8'h60, 60, 60, 1'b1);
        m_ready = 2'b11;
        steps(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
